// File: rtl/pipe_msgbus_ctrl_if.sv
// MAC-side PIPE message bus bundle: per-lane register requests, responses,
// decoded PHY writes and the raw M2P/P2M bytes (lane i in element i).
interface pipe_msgbus_ctrl_if #(parameter int NUM_LANES = 4);
  logic [NUM_LANES-1:0]        req_valid;
  logic [NUM_LANES-1:0]        req_ready;
  logic [NUM_LANES-1:0][1:0]   req_cmd;
  logic [NUM_LANES-1:0][11:0]  req_addr;
  logic [NUM_LANES-1:0][7:0]   req_data;
  logic [NUM_LANES-1:0]        rsp_valid;
  logic [NUM_LANES-1:0]        rsp_kind;
  logic [NUM_LANES-1:0]        rsp_err;
  logic [NUM_LANES-1:0][7:0]   rsp_data;
  logic [NUM_LANES-1:0][7:0]   M2P_MessageBus;
  logic [NUM_LANES-1:0][7:0]   P2M_MessageBus;
  logic [NUM_LANES-1:0]        phy_wr_valid;
  logic [NUM_LANES-1:0]        phy_wr_committed;
  logic [NUM_LANES-1:0][11:0]  phy_wr_addr;
  logic [NUM_LANES-1:0][7:0]   phy_wr_data;

  modport master (
    output req_valid, req_cmd, req_addr, req_data, P2M_MessageBus,
    input  req_ready, rsp_valid, rsp_kind, rsp_err, rsp_data, M2P_MessageBus,
           phy_wr_valid, phy_wr_committed, phy_wr_addr, phy_wr_data
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_data, P2M_MessageBus,
    output req_ready, rsp_valid, rsp_kind, rsp_err, rsp_data, M2P_MessageBus,
           phy_wr_valid, phy_wr_committed, phy_wr_addr, phy_wr_data
  );
endinterface

// File: rtl/pipe_msgbus_ctrl.sv
// PIPE message bus controller: one independent TX serialiser / RX decoder
// per lane, with automatic write_ack generation for PHY committed writes.
module pipe_msgbus_lane #(parameter int TIMEOUT = 64) (
    input  logic        PCLK,
    input  logic        Reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [1:0]  reqCmd,
    input  logic [11:0] reqAddr,
    input  logic [7:0]  reqData,
    output logic        rspValid,
    output logic        rspKind,
    output logic        rspErr,
    output logic [7:0]  rspData,
    output logic [7:0]  m2p,
    input  logic [7:0]  p2m,
    output logic        phyWrValid,
    output logic        phyWrCommitted,
    output logic [11:0] phyWrAddr,
    output logic [7:0]  phyWrData
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
    localparam logic [7:0] ACK_BYTE = 8'h50;

    typedef enum logic [2:0] {IDLE, TX_ADDR, TX_DATA, WAIT_RSP, TX_ACK} txState_t;
    typedef enum logic [1:0] {RIDLE, RADDR, RDATA, RCDATA} rxState_t;

    txState_t txState, txNxt;
    rxState_t rxState, rxNxt;
    logic retWait, retWaitNxt, ackPend, ackPendNxt;
    logic [1:0] cmdQ, cmdNxt;
    logic [11:0] addrQ, addrNxt, rxAddr, rxAddrNxt;
    logic [7:0] dataQ, dataNxt, m2pNxt, rspDataNxt, phyWrDataNxt;
    logic [CW-1:0] cnt, cntNxt;
    logic rxCom, rxComNxt, rspValidNxt, rspKindNxt, rspErrNxt;
    logic phyWrValidNxt, phyWrCommittedNxt;
    logic [11:0] phyWrAddrNxt;
    logic setAck, cplEvt, ackEvt, isRead, match;

    // RX events are combinational so the response lands one cycle after the byte
    assign cplEvt   = (rxState == RCDATA);
    assign ackEvt   = (rxState == RIDLE) && (p2m[7:4] == 4'h5);
    assign isRead   = (cmdQ == 2'b10);
    assign match    = isRead ? cplEvt : ackEvt;
    assign reqReady = (txState == IDLE) && !ackPend;

    always_comb begin
        rxNxt = rxState; rxAddrNxt = rxAddr; rxComNxt = rxCom; setAck = 1'b0;
        phyWrValidNxt = 1'b0; phyWrCommittedNxt = phyWrCommitted;
        phyWrAddrNxt = phyWrAddr; phyWrDataNxt = phyWrData;
        case (rxState)
            RIDLE: begin
                if (p2m[7:4] == 4'h1 || p2m[7:4] == 4'h2) begin
                    rxNxt = RADDR; rxAddrNxt[11:8] = p2m[3:0]; rxComNxt = (p2m[7:4] == 4'h2);
                end else if (p2m[7:4] == 4'h4) begin
                    rxNxt = RCDATA;
                end
            end
            RADDR: begin rxAddrNxt[7:0] = p2m; rxNxt = RDATA; end
            RDATA: begin
                phyWrValidNxt = 1'b1; phyWrCommittedNxt = rxCom;
                phyWrAddrNxt = rxAddr; phyWrDataNxt = p2m;
                setAck = rxCom; rxNxt = RIDLE;
            end
            default: rxNxt = RIDLE;
        endcase
    end

    always_comb begin
        txNxt = txState; retWaitNxt = retWait; cmdNxt = cmdQ; addrNxt = addrQ;
        dataNxt = dataQ; cntNxt = cnt; ackPendNxt = ackPend | setAck; m2pNxt = 8'h00;
        rspValidNxt = 1'b0; rspKindNxt = rspKind; rspErrNxt = rspErr; rspDataNxt = rspData;
        case (txState)
            IDLE: begin
                if (ackPend) begin
                    txNxt = TX_ACK; retWaitNxt = 1'b0; m2pNxt = ACK_BYTE; ackPendNxt = setAck;
                end else if (reqValid) begin
                    cmdNxt = reqCmd; addrNxt = reqAddr; dataNxt = reqData;
                    if (reqCmd != 2'b11) begin
                        txNxt = TX_ADDR;
                        m2pNxt = {{2'b00, reqCmd} + 4'd1, reqAddr[11:8]};
                    end
                end
            end
            TX_ADDR: begin
                m2pNxt = addrQ[7:0];
                if (isRead) begin txNxt = WAIT_RSP; cntNxt = '0; end
                else txNxt = TX_DATA;
            end
            TX_DATA: begin
                m2pNxt = dataQ;
                if (cmdQ == 2'b01) begin txNxt = WAIT_RSP; cntNxt = '0; end
                else txNxt = IDLE;
            end
            WAIT_RSP: begin
                if (match) begin
                    txNxt = IDLE; rspValidNxt = 1'b1; rspKindNxt = !isRead;
                    rspErrNxt = 1'b0; rspDataNxt = isRead ? p2m : 8'h00;
                end else if (ackPend) begin
                    txNxt = TX_ACK; retWaitNxt = 1'b1; m2pNxt = ACK_BYTE; ackPendNxt = setAck;
                end else if (cnt == T_LAST) begin
                    txNxt = IDLE; rspValidNxt = 1'b1; rspKindNxt = !isRead;
                    rspErrNxt = 1'b1; rspDataNxt = 8'h00;
                end else begin
                    cntNxt = cnt + 1'b1;
                end
            end
            TX_ACK: begin
                // a completion arriving while the ack goes out must not be lost
                if (retWait && match) begin
                    txNxt = IDLE; rspValidNxt = 1'b1; rspKindNxt = !isRead;
                    rspErrNxt = 1'b0; rspDataNxt = isRead ? p2m : 8'h00;
                end else begin
                    txNxt = retWait ? WAIT_RSP : IDLE;
                end
            end
            default: txNxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge Reset) begin
        if (!Reset) begin
            txState <= IDLE; rxState <= RIDLE; retWait <= 1'b0; ackPend <= 1'b0;
            cmdQ <= '0; addrQ <= '0; dataQ <= '0; cnt <= '0; m2p <= '0;
            rspValid <= 1'b0; rspKind <= 1'b0; rspErr <= 1'b0; rspData <= '0;
            rxAddr <= '0; rxCom <= 1'b0;
            phyWrValid <= 1'b0; phyWrCommitted <= 1'b0; phyWrAddr <= '0; phyWrData <= '0;
        end else begin
            txState <= txNxt; rxState <= rxNxt; retWait <= retWaitNxt; ackPend <= ackPendNxt;
            cmdQ <= cmdNxt; addrQ <= addrNxt; dataQ <= dataNxt; cnt <= cntNxt; m2p <= m2pNxt;
            rspValid <= rspValidNxt; rspKind <= rspKindNxt; rspErr <= rspErrNxt; rspData <= rspDataNxt;
            rxAddr <= rxAddrNxt; rxCom <= rxComNxt;
            phyWrValid <= phyWrValidNxt; phyWrCommitted <= phyWrCommittedNxt;
            phyWrAddr <= phyWrAddrNxt; phyWrData <= phyWrDataNxt;
        end
    end
endmodule

module pipe_msgbus_ctrl #(
    parameter int NUM_LANES = 4,
    parameter int TIMEOUT   = 64
) (
    input logic PCLK,
    input logic Reset,
    pipe_msgbus_ctrl_if.slave bus
);
    for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
        pipe_msgbus_lane #(.TIMEOUT(TIMEOUT)) uLane (
            .PCLK           (PCLK),
            .Reset          (Reset),
            .reqValid       (bus.req_valid[i]),
            .reqReady       (bus.req_ready[i]),
            .reqCmd         (bus.req_cmd[i]),
            .reqAddr        (bus.req_addr[i]),
            .reqData        (bus.req_data[i]),
            .rspValid       (bus.rsp_valid[i]),
            .rspKind        (bus.rsp_kind[i]),
            .rspErr         (bus.rsp_err[i]),
            .rspData        (bus.rsp_data[i]),
            .m2p            (bus.M2P_MessageBus[i]),
            .p2m            (bus.P2M_MessageBus[i]),
            .phyWrValid     (bus.phy_wr_valid[i]),
            .phyWrCommitted (bus.phy_wr_committed[i]),
            .phyWrAddr      (bus.phy_wr_addr[i]),
            .phyWrData      (bus.phy_wr_data[i])
        );
    end
endmodule
